// File: rtl/icache_dm_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_dm_if
// Purpose  : Line-refill bus between icache_dm and the instruction memory.
//            One outstanding beat at a time; mem_req_o/mem_addr_o are held
//            by the cache until mem_ack_i returns the beat data.
// Revision : 1.0 - initial release
// ============================================================================
interface icache_dm_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  // Cache side issues beats
  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  // Memory side answers beats
  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// Module   : icache_dm
// Purpose  : Direct-mapped read-only instruction cache. Combinational hit
//            path to the fetch stage; on a miss the pipeline is stalled and a
//            whole line is refilled word by word over icache_dm_if.
//            Optional macro ICACHE_STATS_EN adds hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module icache_dm #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS - 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [31:0] addr_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic        stallreq_o,
  icache_dm_if.master mem
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    FILL_DONE = 2'd2
  } state_e;

  // Fetch address fields
  logic [OFFSET_BITS-1:0] w_off;
  logic [INDEX_BITS-1:0]  w_idx;
  logic [TAG_BITS-1:0]    w_tag;
  logic                   unused_addr_lsb;

  assign w_off           = addr_i[OFFSET_BITS+1:2];
  assign w_idx           = addr_i[OFFSET_BITS+INDEX_BITS+1 -: INDEX_BITS];
  assign w_tag           = addr_i[31 -: TAG_BITS];
  assign unused_addr_lsb = ^addr_i[1:0];

  // Storage: only the valid bits carry reset
  logic [31:0]         data_arr [LINES*WORDS];
  logic [TAG_BITS-1:0] tag_arr  [LINES];
  logic [LINES-1:0]    valid_q;

  // Refill control
  state_e                 state_q, state_d;
  logic [OFFSET_BITS-1:0] count_q, count_d;
  logic [TAG_BITS-1:0]    tag_q, tag_d;
  logic [INDEX_BITS-1:0]  idx_q, idx_d;
  logic                   drop_q, drop_d;

  logic w_hit;
  logic w_start;
  logic w_beat;
  logic w_last;
  logic w_fill_valid;

  assign w_hit = ce_i & valid_q[w_idx] & (tag_arr[w_idx] == w_tag) & (state_q == IDLE);

  // Core-facing outputs are forced quiet while reset is asserted
  assign inst_o     = (rst && w_hit) ? data_arr[{w_idx, w_off}] : 32'h0;
  assign stallreq_o = rst & ((state_q != IDLE) | (ce_i & ~w_hit));

  // Beat request is a pure function of the refill registers, so it is
  // naturally stable until the ack advances the word counter
  assign mem.mem_req_o  = (state_q == REFILL);
  assign mem.mem_addr_o = {tag_q, idx_q, count_q, 2'b00};

  // A line that saw a flush at any point of its refill must stay invalid
  assign w_fill_valid = w_last & ~drop_q & ~flush_i;

  // State and refill-control registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic: miss detection, beat sequencing, flush tracking
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    drop_d  = drop_q;
    w_start = 1'b0;
    w_beat  = 1'b0;
    w_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ce_i && !w_hit) begin
          tag_d   = w_tag;
          idx_d   = w_idx;
          count_d = '0;
          w_start = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (flush_i) begin
          drop_d = 1'b1;
        end
        if (mem.mem_ack_i) begin
          w_beat  = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == '1) begin
            w_last  = 1'b1;
            state_d = FILL_DONE;
          end
        end
      end
      FILL_DONE: begin
        // Extra cycle so the IDLE re-lookup reads the freshly written line
        drop_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Valid bits: reset and flush clear everything, a clean fill sets one line
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (w_fill_valid) begin
      valid_q[idx_q] <= 1'b1;
    end
  end

  // Data and tag arrays; a beat landing while reset is asserted is dropped
  always_ff @(posedge clk) begin
    if (rst && w_beat) begin
      data_arr[{idx_q, count_q}] <= mem.mem_rdata_i;
    end
    if (rst && w_last) begin
      tag_arr[idx_q] <= tag_q;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Free-running wrap-around statistics, untouched by flush
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (w_hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (w_start) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
`default_nettype wire
